// File: rtl/axis_vector_checker_if.sv
// rtl/axis_vector_checker_if.sv - AXI-Stream signal bundle with master/slave views
interface axis_vector_checker_if #(
   parameter int DATA_WIDTH = 512
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_vector_checker.sv
// rtl/axis_vector_checker.sv - pass-through AXI-Stream vector format checker
// Optional data sequence check enabled by macro AXIS_VEC_CHECKER_SEQ_CHK_EN.
module axis_vector_checker #(
   parameter int                    DATA_WIDTH = 512,
   parameter int                    VEC_LEN    = 12,
   parameter int                    MARK_WIDTH = 8,
   parameter logic [MARK_WIDTH-1:0] MARKER     = 8'h9E
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axis_vector_checker_if.slave  s_axis,
   axis_vector_checker_if.master m_axis,
   input  logic                  stat_clr,
   output logic                  vec_done,
   output logic                  err_pulse,
   output logic [2:0]            err_code,
   output logic [31:0]           vec_count,
   output logic [15:0]           err_count
);
   localparam logic [7:0] LAST_IDX = 8'(VEC_LEN - 1);

   typedef enum logic [1:0] {EXP_DATA, EXP_MARK, DRAIN} state_t;

   state_t                state, state_nxt;
   logic [7:0]            idx, idx_nxt;
   logic                  accept;
   logic                  mark_ok;
   logic                  err_hit, done_hit;
   logic [2:0]            code_nxt;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid, out_last;

`ifdef AXIS_VEC_CHECKER_SEQ_CHK_EN
   logic seq_bad;
   assign seq_bad = s_axis.tdata[7:0] != (idx + 8'd1);
`endif

   assign s_axis.tready = !out_valid || m_axis.tready;
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign mark_ok       = s_axis.tdata[MARK_WIDTH-1:0] == MARKER;

   assign m_axis.tdata  = out_data;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_last;

   // Single-stage output register; holds while downstream stalls.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_data  <= s_axis.tdata;
         out_valid <= 1'b1;
         out_last  <= s_axis.tlast;
      end else if (m_axis.tready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= EXP_DATA;
         idx   <= 8'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (accept) begin
         case (state)
            EXP_DATA: begin
               if (s_axis.tlast) idx_nxt = 8'd0;
`ifdef AXIS_VEC_CHECKER_SEQ_CHK_EN
               else if (seq_bad) state_nxt = DRAIN;
`endif
               else state_nxt = EXP_MARK;
            end
            EXP_MARK: begin
               if (s_axis.tlast) begin
                  state_nxt = EXP_DATA;
                  idx_nxt   = 8'd0;
               end else if (!mark_ok || idx == LAST_IDX) begin
                  state_nxt = DRAIN;
               end else begin
                  state_nxt = EXP_DATA;
                  idx_nxt   = idx + 8'd1;
               end
            end
            default: begin
               if (s_axis.tlast) begin
                  state_nxt = EXP_DATA;
                  idx_nxt   = 8'd0;
               end
            end
         endcase
      end
   end

   // Event decode: at most one error or one completion per accepted beat.
   always_comb begin
      err_hit  = 1'b0;
      done_hit = 1'b0;
      code_nxt = 3'd0;
      if (accept) begin
         case (state)
            EXP_DATA: begin
`ifdef AXIS_VEC_CHECKER_SEQ_CHK_EN
               if (seq_bad) begin
                  err_hit  = 1'b1;
                  code_nxt = 3'd4;
               end else
`endif
               if (s_axis.tlast) begin
                  err_hit  = 1'b1;
                  code_nxt = 3'd2;
               end
            end
            EXP_MARK: begin
               if (!mark_ok) begin
                  err_hit  = 1'b1;
                  code_nxt = 3'd1;
               end else if (idx != LAST_IDX) begin
                  if (s_axis.tlast) begin
                     err_hit  = 1'b1;
                     code_nxt = 3'd2;
                  end
               end else if (s_axis.tlast) begin
                  done_hit = 1'b1;
               end else begin
                  err_hit  = 1'b1;
                  code_nxt = 3'd3;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         vec_done  <= 1'b0;
         err_pulse <= 1'b0;
         err_code  <= 3'd0;
         vec_count <= 32'd0;
         err_count <= 16'd0;
      end else begin
         vec_done  <= done_hit;
         err_pulse <= err_hit;
         err_code  <= code_nxt;
         if (stat_clr) begin
            vec_count <= 32'd0;
            err_count <= 16'd0;
         end else begin
            if (done_hit) vec_count <= vec_count + 32'd1;
            if (err_hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_axis_vector_checker.sv
// tb/tb_axis_vector_checker.sv - scoreboard bench for axis_vector_checker
module tb_axis_vector_checker;
   localparam int DW = 512;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        stat_clr = 1'b0;
   logic        vec_done, err_pulse;
   logic [2:0]  err_code;
   logic [31:0] vec_count;
   logic [15:0] err_count;

   axis_vector_checker_if #(.DATA_WIDTH(DW)) s_axis ();
   axis_vector_checker_if #(.DATA_WIDTH(DW)) m_axis ();

   axis_vector_checker #(.DATA_WIDTH(DW)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .s_axis    (s_axis),
      .m_axis    (m_axis),
      .stat_clr  (stat_clr),
      .vec_done  (vec_done),
      .err_pulse (err_pulse),
      .err_code  (err_code),
      .vec_count (vec_count),
      .err_count (err_count)
   );

   always #5 aclk = ~aclk;

   int    n_assert = 0;
   int    n_fail = 0;
   int    cyc = 0;
   bit    stall_en = 1'b0;
   beat_t exp_q[$];
   int    ev_q[$];
   int    exp_vec = 0;
   int    exp_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Downstream ready: 2 low / 6 high when stalling.
   initial begin
      m_axis.tready = 1'b1;
      forever begin
         @(negedge aclk);
         cyc++;
         m_axis.tready = stall_en ? ((cyc % 8) >= 2) : 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge aclk);
         #2;
         if (aresetn) begin
            if (m_axis.tvalid) begin
               n_assert++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL out_beat: unexpected beat low=%h expected none", m_axis.tdata[31:0]);
               end else begin
                  if (m_axis.tdata !== exp_q[0].d || m_axis.tlast !== exp_q[0].l) begin
                     n_fail++;
                     $display("FAIL out_beat: got %h/%b expected %h/%b",
                              m_axis.tdata[63:0], m_axis.tlast, exp_q[0].d[63:0], exp_q[0].l);
                  end
                  if (m_axis.tready) void'(exp_q.pop_front());
               end
            end
            if (vec_done || err_pulse) begin
               int code;
               code = vec_done ? (err_pulse ? 9 : 0) : int'(err_code);
               if (ev_q.size() == 0) begin
                  n_assert++;
                  n_fail++;
                  $display("FAIL event: got code %0d expected no event", code);
               end else begin
                  chk("event", 64'(code), 64'(ev_q.pop_front()));
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] mkbeat(input logic [7:0] lo);
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      v[7:0] = lo;
      return v;
   endfunction

   task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic clr);
      int    budget;
      beat_t b;
      budget = 0;
      @(negedge aclk);
      s_axis.tdata  = d;
      s_axis.tlast  = l;
      s_axis.tvalid = 1'b1;
      stat_clr      = clr;
      #1;
      while (!s_axis.tready && budget < 200) begin
         budget++;
         @(negedge aclk);
         #1;
      end
      if (!s_axis.tready) begin
         n_assert++;
         n_fail++;
         $display("FAIL accept_timeout: got tready=0 expected 1");
      end else begin
         b.d = d;
         b.l = l;
         exp_q.push_back(b);
         @(posedge aclk);
      end
      #1;
      s_axis.tvalid = 1'b0;
      stat_clr      = 1'b0;
   endtask

   // beat numbering is 1-based; element e has data beat 2e-1 and marker beat 2e.
   task automatic send_vec(input int n_elem, input int last_beat, input int bad_mark,
                           input int bad_data_elem, input logic [7:0] bad_data, input bit clr_last);
      for (int b = 1; b <= 2 * n_elem; b++) begin
         int         e;
         logic [7:0] lo;
         e = (b + 1) / 2;
         if (b % 2 == 1) lo = (e == bad_data_elem) ? bad_data : 8'(e);
         else            lo = (e == bad_mark) ? 8'h00 : 8'h9E;
         send_beat(mkbeat(lo), b == last_beat, clr_last && (b == 2 * n_elem));
      end
   endtask

   task automatic drain_and_check(input string tag);
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 300) begin
         budget++;
         @(negedge aclk);
      end
      repeat (3) @(negedge aclk);
      #3;
      chk({tag, "_outq_empty"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_evq_empty"}, 64'(ev_q.size()), 64'd0);
      chk({tag, "_vec_count"}, 64'(vec_count), 64'(exp_vec));
      chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
   endtask

   initial begin
      s_axis.tdata  = '0;
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      repeat (3) @(negedge aclk);
      #3;
      chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
      chk("rst_tlast", 64'(m_axis.tlast), 64'd0);
      chk("rst_tdata_zero", 64'(m_axis.tdata != '0), 64'd0);
      chk("rst_vec_done", 64'(vec_done), 64'd0);
      chk("rst_err_pulse", 64'(err_pulse), 64'd0);
      chk("rst_err_code", 64'(err_code), 64'd0);
      chk("rst_vec_count", 64'(vec_count), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      aresetn = 1'b1;

      ev_q.push_back(0); exp_vec = 1;
      send_vec(12, 24, 0, 0, 8'h00, 1'b0);
      drain_and_check("clean");

      stall_en = 1'b1;
      ev_q.push_back(0); exp_vec = 2;
      send_vec(12, 24, 0, 0, 8'h00, 1'b0);
      drain_and_check("stall");
      stall_en = 1'b0;

      ev_q.push_back(1); ev_q.push_back(0); exp_err = 1; exp_vec = 3;
      send_vec(12, 24, 5, 0, 8'h00, 1'b0);
      send_vec(12, 24, 0, 0, 8'h00, 1'b0);
      drain_and_check("bad_mark");

      ev_q.push_back(2); exp_err = 2;
      send_vec(5, 10, 0, 0, 8'h00, 1'b0);
      drain_and_check("early_last");

      ev_q.push_back(3); ev_q.push_back(0); exp_err = 3; exp_vec = 4;
      send_vec(13, 26, 0, 0, 8'h00, 1'b0);
      send_vec(12, 24, 0, 0, 8'h00, 1'b0);
      drain_and_check("missing_last");

      ev_q.push_back(2); exp_err = 4;
      send_beat(mkbeat(8'h01), 1'b1, 1'b0);
      drain_and_check("last_on_data");

`ifdef AXIS_VEC_CHECKER_SEQ_CHK_EN
      ev_q.push_back(4); exp_err = 5;
`else
      ev_q.push_back(0); exp_vec = 5;
`endif
      send_vec(12, 24, 0, 3, 8'h07, 1'b0);
      drain_and_check("seq_data");

      send_vec(5, 0, 0, 0, 8'h00, 1'b0);
      repeat (2) @(negedge aclk);
      #3;
      aresetn = 1'b0;
      exp_q.delete();
      exp_vec = 0;
      exp_err = 0;
      @(negedge aclk);
      #3;
      chk("midrst_vec_count", 64'(vec_count), 64'd0);
      chk("midrst_tvalid", 64'(m_axis.tvalid), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      ev_q.push_back(0); exp_vec = 1;
      send_vec(12, 24, 0, 0, 8'h00, 1'b0);
      drain_and_check("after_reset");

      ev_q.push_back(0); exp_vec = 0;
      send_vec(12, 24, 0, 0, 8'h00, 1'b1);
      drain_and_check("clr_with_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/axis_vector_checker.md
AXIS_VECTOR_CHECKER -- requirements
Module: axis_vector_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 512, SHALL set the tdata width in bits (multiple of 8, minimum 16).
REQ-002 Parameter VEC_LEN, default 12, SHALL set the number of elements per vector (range 1..255).
REQ-003 Parameter MARK_WIDTH, default 8, SHALL set the number of low tdata bits compared against the marker.
REQ-004 Parameter MARKER, default 8'h9E, SHALL set the expected marker value.
REQ-005 aclk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 s_axis_tdata  in  DATA_WIDTH  upstream data.
REQ-008 s_axis_tvalid / s_axis_tlast  in  1 each  upstream valid / last.
REQ-009 s_axis_tready  out  1  upstream ready.
REQ-010 m_axis_tdata  out  DATA_WIDTH  downstream data.
REQ-011 m_axis_tvalid / m_axis_tlast  out  1 each  downstream valid / last.
REQ-012 m_axis_tready  in  1  downstream ready.
REQ-013 stat_clr  in  1  synchronous clear of the counters.
REQ-014 vec_done  out  1  one-cycle pulse per error-free vector.
REQ-015 err_pulse  out  1  one-cycle pulse per detected error.
REQ-016 err_code  out  3  error type, valid with err_pulse.
REQ-017 vec_count  out  32  count of error-free vectors.
REQ-018 err_count  out  16  count of errors, saturating at 16'hFFFF.

Function
REQ-019 Accept is s_axis_tvalid && s_axis_tready; s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready.
REQ-020 Each accepted beat SHALL appear unmodified on m_axis_* one cycle later; m_axis_tvalid SHALL hold with stable data until m_axis_tready; data SHALL pass regardless of errors.
REQ-021 Vector format: VEC_LEN elements, each a data beat followed by a marker beat; tlast only on the final marker beat (2*VEC_LEN beats).
REQ-022 FSM states: EXP_DATA (reset state), EXP_MARK, DRAIN; an element index 0..VEC_LEN-1 SHALL advance on each accepted marker beat.
REQ-023 EXP_DATA, accepted beat, tlast=0: go to EXP_MARK.
REQ-024 EXP_DATA, accepted beat, tlast=1: error code 2 (early last); index to 0; stay EXP_DATA.
REQ-025 EXP_MARK, tdata[MARK_WIDTH-1:0] != MARKER: error code 1; go to DRAIN, or to EXP_DATA with index 0 if tlast=1.
REQ-026 EXP_MARK, marker correct, index < VEC_LEN-1: tlast=0 goes to EXP_DATA with index+1; tlast=1 is error code 2, EXP_DATA, index 0.
REQ-027 EXP_MARK, marker correct, index == VEC_LEN-1: tlast=1 pulses vec_done, increments vec_count, index 0, EXP_DATA; tlast=0 is error code 3 (missing last), go to DRAIN.
REQ-028 DRAIN SHALL discard checks until an accepted beat with tlast=1, then go to EXP_DATA with index 0; no further errors are reported while in DRAIN.
REQ-029 At most one error SHALL be flagged per beat; err_pulse, err_code and vec_done SHALL be registered, asserting the cycle after the accept.
REQ-030 vec_count SHALL wrap at 2^32; err_count SHALL saturate.
REQ-031 stat_clr SHALL zero both counters on the next edge and win over a simultaneous increment; FSM state is unaffected.

Reset
REQ-032 While aresetn is low: m_axis_tvalid, m_axis_tlast, vec_done, err_pulse=0; err_code=0; m_axis_tdata=0; counters=0; FSM=EXP_DATA; index=0.
REQ-033 Reset mid-vector SHALL abandon the vector silently; the first beat accepted after reset is treated as element 0 data.

Configuration
REQ-034 Macro AXIS_VEC_CHECKER_SEQ_CHK_EN defined: each EXP_DATA beat's tdata[7:0] SHALL equal index+1 (mod 256), otherwise error code 4 with the same transitions as REQ-025.
REQ-035 Macro undefined: no sequence check, code 4 never produced, the related logic SHALL be absent.

Verification
REQ-036 12 elements (data 1..12, marker 8'h9E, tlast on beat 24), m_axis_tready=1 -> one vec_done, vec_count=1, err_count=0, 24 identical output beats.
REQ-037 Same stream with tready toggling 2 low / 6 high -> no beat lost or duplicated, output data stable while stalled, vec_count=1.
REQ-038 Element 5 marker = 8'h00 -> err_code=1 once, no vec_done, error-free vector that follows gives vec_count=1.
REQ-039 tlast on beat 10 -> err_code=2; tlast missing on beat 24, present on beat 26 -> err_code=3, DRAIN exits on beat 26.
REQ-040 SEQ_CHK_EN defined, element 3 data = 8'h07 -> err_code=4; undefined -> vec_done.
REQ-041 aresetn pulsed low at beat 11, then a full vector -> no error, vec_count=1; stat_clr together with vec_done -> vec_count=0.
